upstream_mem_writer: RTL
========================

Name: upstream_mem_writer

Overview:
- Initiator side of the ack/memwr write-update handshake with downstream_processor.
- Buffers incoming write requests and signals the downstream with a one-cycle `ack` pulse.
- Waits for the downstream busy indication, performs the memory write, then releases the downstream with a one-cycle `memwr` pulse.
- Sits between the cache write path and the downstream processor/memory port.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory data width.
- DEPTH, 4, request FIFO entries (power of two, >=2).
- WR_CYCLES, 2, cycles mem_we held per write (>=1).
- TIMEOUT, 16, max cycles waiting on ds_busy edge before abort (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  write request valid.
- req_ready  out  1  FIFO can accept (= not full).
- req_addr  in  ADDR_W  request address.
- req_data  in  DATA_W  request data.
- ack  out  1  one-cycle start pulse to downstream.
- memwr  out  1  one-cycle release pulse to downstream.
- ds_busy  in  1  downstream update-in-progress (downstream `out`).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address (held request).
- mem_wdata  out  DATA_W  memory data (held request).
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  one-cycle pulse on handshake abort.

Behaviour:
Interface decisions:
- One clock `clk`.
- Reset `rst` is synchronous, active-high.

Reset:
- State returns to IDLE and the FIFO is emptied.
- Counters and hold registers are cleared to 0.
- All outputs are 0, except req_ready, which is 1 from the first cycle after reset.
- Reset mid-operation aborts immediately. No memwr is issued, and the downstream is left to time out on its own.

FIFO:
- Push on a cycle with req_valid && req_ready.
- req_ready = !full, with no bypass when full even if a pop occurs the same cycle.
- Simultaneous push and pop when not full: occupancy unchanged, both take effect.
- Pointers wrap modulo DEPTH.
- Occupancy counter is width clog2(DEPTH)+1.

FSM:
- State is registered.
- ack, memwr and mem_we are decoded from the current state, so each is valid in the cycle its state is occupied.
- IDLE:
  - If FIFO is non-empty: pop the head into the addr/data hold registers and go to SEND_ACK.
  - Otherwise stay in IDLE.
- SEND_ACK:
  - ack=1 for exactly one cycle.
  - Go to WAIT_BUSY and clear the wait counter.
- WAIT_BUSY:
  - If ds_busy=1: go to WRITE and load the write counter.
  - Otherwise increment the wait counter.
  - When the count reaches TIMEOUT-1 without ds_busy: pulse timeout_err, discard the request, go to IDLE.
- WRITE:
  - mem_we=1 with mem_addr/mem_wdata from the hold registers.
  - Stay for exactly WR_CYCLES cycles, then go to RELEASE.
- RELEASE:
  - memwr=1 for exactly one cycle.
  - Go to WAIT_IDLE and clear the wait counter.
- WAIT_IDLE:
  - If ds_busy=0: go to IDLE.
  - If the wait counter reaches TIMEOUT-1: pulse timeout_err and go to IDLE.

Outputs and timing:
- mem_addr and mem_wdata always reflect the hold registers. They are stable from SEND_ACK through WAIT_IDLE.
- busy = (state != IDLE).
- Latency: with an idle FSM and empty FIFO, a push at edge T gives pop at edge T+1 and ack high in cycle T+1..T+2.
- Best-case request period: 1 (IDLE) + 1 (SEND_ACK) + 1 (WAIT_BUSY) + WR_CYCLES + 1 (RELEASE) + 1 (WAIT_IDLE) cycles.
- Requests are issued strictly one at a time in FIFO order. ack is never re-asserted until the FSM has returned to IDLE.
- A ds_busy glitch while in WRITE is ignored. The write always completes WR_CYCLES cycles.

Test Plan:
- Single request: reset, push addr=0x10, data=0xDEADBEEF, downstream model sets ds_busy the cycle after ack and clears it the cycle after memwr.
  -> Exactly one ack pulse, mem_we high 2 cycles with 0x10/0xDEADBEEF, one memwr pulse, busy returns to 0.
- Back-to-back: push 4 requests (addr 1..4) consecutively.
  -> req_ready=0 only after the 4th push while FSM has not yet popped; 4 ack/memwr pairs issued in order 1,2,3,4; no overlap.
- FIFO full: push 5 requests while ds_busy is held 0 externally.
  -> 5th push stalls (req_ready=0) until the first pop.
  -> Simultaneous push and pop keeps occupancy constant.
- Timeout: ds_busy never rises after ack.
  -> timeout_err pulses exactly once, 16 cycles after WAIT_BUSY entry; no mem_we, no memwr; next request then proceeds normally.
- Stuck release: ds_busy stays 1 after memwr.
  -> timeout_err after 16 cycles in WAIT_IDLE, FSM returns to IDLE.
- Reset mid-write: assert rst during the 1st WRITE cycle.
  -> Next cycle mem_we=0, memwr never pulses, FIFO empty, req_ready=1, busy=0.

Source files
------------

// File: rtl/upstream_mem_writer.sv
// Initiator side of the ack/memwr write-update handshake: buffers write
// requests, signals the downstream, performs the memory write, releases it.
module upstream_mem_writer #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int WR_CYCLES = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack,
    output logic              memwr,
    input  logic              ds_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int WW = $clog2(WR_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WLAST = WW'(WR_CYCLES - 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SEND_ACK,
        WAIT_BUSY,
        WRITE,
        RELEASE,
        WAIT_IDLE
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] fa [DEPTH];
    logic [DATA_W-1:0] fd [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [CW-1:0]     cnt;
    logic              push_en;
    logic              pop_en;

    logic [ADDR_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_d;
    logic [TW-1:0]     wait_cnt;
    logic [WW-1:0]     wr_cnt;

    // No bypass: a full FIFO refuses even when a pop happens this cycle.
    assign req_ready = (cnt != FULL);
    assign push_en   = req_valid && req_ready;
    assign pop_en    = (state == IDLE) && (cnt != '0);

    always_ff @(posedge clk) begin
        if (push_en) begin
            fa[wp] <= req_addr;
            fd[wp] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_en)
                wp <= wp + 1'b1;
            if (pop_en)
                rp <= rp + 1'b1;
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_a      <= '0;
            hold_d      <= '0;
            wait_cnt    <= '0;
            wr_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop_en) begin
                        hold_a <= fa[rp];
                        hold_d <= fd[rp];
                        state  <= SEND_ACK;
                    end
                end
                SEND_ACK: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (ds_busy) begin
                        wr_cnt <= WLAST;
                        state  <= WRITE;
                    end else if (wait_cnt == TLAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // ds_busy is deliberately ignored while the write runs
                WRITE: begin
                    if (wr_cnt == '0)
                        state <= RELEASE;
                    else
                        wr_cnt <= wr_cnt - 1'b1;
                end
                RELEASE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (!ds_busy) begin
                        state <= IDLE;
                    end else if (wait_cnt == TLAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ack       = (state == SEND_ACK);
    assign memwr     = (state == RELEASE);
    assign mem_we    = (state == WRITE);
    assign busy      = (state != IDLE);
    assign mem_addr  = hold_a;
    assign mem_wdata = hold_d;

endmodule
